// File: rtl/spi_cfg_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_cfg_ctrl_if
// Description : Host word bus and active SPI configuration outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_cfg_ctrl_if;
    logic       config_req;
    logic [5:0] config_data;
    logic       cpol;
    logic       cpha;
    logic [3:0] spi_width;
    logic       cfg_update;
    logic       cfg_err;

    modport master (
        output config_req,
        output config_data,
        input  cpol,
        input  cpha,
        input  spi_width,
        input  cfg_update,
        input  cfg_err
    );

    modport slave (
        input  config_req,
        input  config_data,
        output cpol,
        output cpha,
        output spi_width,
        output cfg_update,
        output cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_cfg_ctrl
// Description : Word-serial SPI configuration controller with shadow/commit.
//               Optional odd parity on data words: SPI_CFG_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cfg_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int TIMEOUT_CYC   = 1023,
    parameter int DEFAULT_WIDTH = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    spi_cfg_ctrl_if.slave cfg_if
);

    localparam int             c_CW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT_CYC - 1);
    localparam logic [c_CW-1:0] c_CNT_MAX  = {c_CW{1'b1}};
    localparam logic [3:0]      c_DEF_W    = 4'(DEFAULT_WIDTH);

    localparam logic [1:0] c_CMD_WRITE  = 2'b01;
    localparam logic [1:0] c_CMD_COMMIT = 2'b10;
    localparam logic [1:0] c_CMD_ABORT  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_DATA = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic [5:0]            r_data_sync [SYNC_STAGES];
    logic                  r_req_d;
    logic                  r_armed;
    logic [3:0]            r_addr;
    logic [c_CW-1:0]       r_cnt;
    logic [c_CW-1:0]       w_cnt_next;
    logic                  r_cpol, r_cpha, r_sh_cpol, r_sh_cpha;
    logic [3:0]            r_width, r_sh_width;
    logic                  r_update;
    logic                  r_err;

    logic                  w_req_s;
    logic [5:0]            w_data_s;
    logic                  w_edge;
    logic                  w_parity_ok;
    logic                  w_latch_addr, w_commit, w_abort;
    logic                  w_ld_pol, w_ld_width, w_set_err;

    assign w_req_s  = r_req_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_edge   = w_req_s & ~r_req_d & r_armed;

`ifdef SPI_CFG_PARITY_EN
    assign w_parity_ok = ^w_data_s;
`else
    assign w_parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_latch_addr = 1'b0;
        w_commit     = 1'b0;
        w_abort      = 1'b0;
        w_ld_pol     = 1'b0;
        w_ld_width   = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    case (w_data_s[5:4])
                        c_CMD_WRITE: begin
                            w_latch_addr = 1'b1;
                            w_cnt_next   = '0;
                            w_state_next = ST_WAIT_DATA;
                        end
                        c_CMD_COMMIT: w_commit = 1'b1;
                        c_CMD_ABORT:  w_abort  = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_WAIT_DATA: begin
                // A data edge landing on the final count still wins over the timeout.
                if (w_edge) begin
                    w_state_next = ST_IDLE;
                    if (!w_parity_ok) begin
                        w_set_err = 1'b1;
                    end else if (r_addr == 4'd0) begin
                        w_ld_pol = 1'b1;
                    end else if (r_addr == 4'd1) begin
                        if (w_data_s[3:0] == 4'd0) begin
                            w_set_err = 1'b1;
                        end else begin
                            w_ld_width = 1'b1;
                        end
                    end else begin
                        w_set_err = 1'b1;
                    end
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next = ST_IDLE;
                    w_set_err    = 1'b1;
                end else if (r_cnt != c_CNT_MAX) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_sync <= '0;
            r_fill     <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= '0;
            end
            r_req_d    <= 1'b0;
            r_armed    <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_width    <= c_DEF_W;
            r_sh_cpol  <= 1'b0;
            r_sh_cpha  <= 1'b0;
            r_sh_width <= c_DEF_W;
            r_update   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_req_sync     <= {r_req_sync[SYNC_STAGES-2:0], cfg_if.config_req};
            r_data_sync[0] <= cfg_if.config_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= r_data_sync[i-1];
            end
            // req_s only reflects the pad once the chain has refilled after reset.
            r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_req_d <= w_req_s;
            if (r_fill[SYNC_STAGES-1] && !w_req_s) begin
                r_armed <= 1'b1;
            end
            if (w_latch_addr) begin
                r_addr <= w_data_s[3:0];
            end
            r_cnt    <= w_cnt_next;
            r_update <= w_commit;
            if (w_commit) begin
                r_cpol  <= r_sh_cpol;
                r_cpha  <= r_sh_cpha;
                r_width <= r_sh_width;
                r_err   <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (w_abort) begin
                r_sh_cpol  <= r_cpol;
                r_sh_cpha  <= r_cpha;
                r_sh_width <= r_width;
            end
            if (w_ld_pol) begin
                r_sh_cpol <= w_data_s[0];
                r_sh_cpha <= w_data_s[1];
            end
            if (w_ld_width) begin
                r_sh_width <= w_data_s[3:0];
            end
        end
    end

    assign cfg_if.cpol       = r_cpol;
    assign cfg_if.cpha       = r_cpha;
    assign cfg_if.spi_width  = r_width;
    assign cfg_if.cfg_update = r_update;
    assign cfg_if.cfg_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_cfg_ctrl
// Description : Self-checking bench for spi_cfg_ctrl (transaction-level model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cfg_ctrl;

    localparam int S  = 2;
    localparam int T  = 12;
    localparam int DW = 8;
    localparam int G  = 2 * S + 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_cfg_ctrl_if u_if ();

    spi_cfg_ctrl #(
        .SYNC_STAGES  (S),
        .TIMEOUT_CYC  (T),
        .DEFAULT_WIDTH(DW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cfg_if(u_if.slave)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a word takes effect S+1 posedges after req rises.
    typedef struct {
        int         eff;
        logic [5:0] w;
    } ev_t;
    ev_t q[$];

    int         cyc = 0;
    logic       m_valid = 1'b0;
    logic       m_cpol, m_cpha, m_sh_cpol, m_sh_cpha, m_upd, m_err, m_wait;
    logic [3:0] m_width, m_sh_width, m_addr;
    int         m_left;

    task automatic model_word(input logic [5:0] w);
        logic par_ok;
        if (!m_wait) begin
            case (w[5:4])
                2'd1: begin m_wait = 1'b1; m_addr = w[3:0]; m_left = T; end
                2'd2: begin
                    m_cpol = m_sh_cpol; m_cpha = m_sh_cpha; m_width = m_sh_width;
                    m_err = 1'b0; m_upd = 1'b1;
                end
                2'd3: begin m_sh_cpol = m_cpol; m_sh_cpha = m_cpha; m_sh_width = m_width; end
                default: ;
            endcase
        end else begin
            m_wait = 1'b0;
`ifdef SPI_CFG_PARITY_EN
            par_ok = ($countones(w) % 2) == 1;
`else
            par_ok = 1'b1;
`endif
            if (!par_ok) m_err = 1'b1;
            else if (m_addr == 4'd0) begin m_sh_cpol = w[0]; m_sh_cpha = w[1]; end
            else if (m_addr == 4'd1) begin
                if (w[3:0] == 4'd0) m_err = 1'b1;
                else m_sh_width = w[3:0];
            end else m_err = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        m_upd = 1'b0;
        if (rst) begin
            m_valid = 1'b1;
            m_cpol = 1'b0; m_cpha = 1'b0; m_width = 4'(DW);
            m_sh_cpol = 1'b0; m_sh_cpha = 1'b0; m_sh_width = 4'(DW);
            m_err = 1'b0; m_wait = 1'b0; m_addr = '0; m_left = 0;
            q.delete();
        end else if (q.size() > 0 && q[0].eff == cyc) begin
            ev_t e;
            e = q.pop_front();
            model_word(e.w);
        end else if (m_wait) begin
            m_left--;
            if (m_left == 0) begin
                m_wait = 1'b0;
                m_err  = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("cpol",       int'(u_if.cpol),       int'(m_cpol));
            chk("cpha",       int'(u_if.cpha),       int'(m_cpha));
            chk("spi_width",  int'(u_if.spi_width),  int'(m_width));
            chk("cfg_update", int'(u_if.cfg_update), int'(m_upd));
            chk("cfg_err",    int'(u_if.cfg_err),    int'(m_err));
        end
    end

    function automatic logic [5:0] fp(input logic [5:0] d);
`ifdef SPI_CFG_PARITY_EN
        logic [5:0] r;
        r    = {1'b0, d[4:0]};
        r[5] = ~(^d[4:0]);
        return r;
`else
        return d;
`endif
    endfunction

    // Called just after a negedge; holds req high, drops it, idles to 'gap' cycles.
    task automatic send(input logic [5:0] w, input int gap);
        ev_t e;
        u_if.config_data = w;
        u_if.config_req  = 1'b1;
        e.eff = cyc + S + 1;
        e.w   = w;
        q.push_back(e);
        repeat (S + 2) @(negedge clk);
        u_if.config_req = 1'b0;
        repeat (gap - (S + 2)) @(negedge clk);
    endtask

    initial begin
        rst              = 1'b1;
        u_if.config_req  = 1'b1;
        u_if.config_data = 6'h20;
        repeat (4) @(negedge clk);
        chk("reset width", int'(u_if.spi_width), DW);
        chk("reset err",   int'(u_if.cfg_err),    0);
        rst = 1'b0;
        // req still high from before reset: must not be taken as a word
        repeat (8) @(negedge clk);
        chk("no word while req held", int'(u_if.cfg_update), 0);
        u_if.config_req = 1'b0;
        repeat (6) @(negedge clk);
        send(6'h20, G);
        chk("commit1 width", int'(u_if.spi_width), 8);
        chk("commit1 cpol",  int'(u_if.cpol),      0);

        send(6'h10, G); send(fp(6'h03), G);
        send(6'h11, G); send(fp(6'h04), G);
        chk("write-only cpol",  int'(u_if.cpol),      0);
        chk("write-only width", int'(u_if.spi_width), 8);
        send(6'h20, G);
        chk("commit2 cpol",  int'(u_if.cpol),      1);
        chk("commit2 cpha",  int'(u_if.cpha),      1);
        chk("commit2 width", int'(u_if.spi_width), 4);

        send(6'h11, G); send(fp(6'h00), G);
        chk("zero width err", int'(u_if.cfg_err), 1);
        send(6'h20, G);
        chk("commit clears err", int'(u_if.cfg_err),   0);
        chk("zero width kept",   int'(u_if.spi_width), 4);

        send(6'h11, G);
        repeat (T + 4) @(negedge clk);
        chk("timeout err", int'(u_if.cfg_err), 1);
        send(6'h05, G);
        send(6'h20, G);
        chk("nop after timeout width", int'(u_if.spi_width), 4);

        send(6'h11, T); send(fp(6'h06), G);
        send(6'h20, G);
        chk("edge at timeout wins", int'(u_if.spi_width), 6);
        send(6'h11, T + 1); send(fp(6'h07), G);
        chk("one past timeout err", int'(u_if.cfg_err), 1);
        send(6'h20, G);
        chk("one past timeout width", int'(u_if.spi_width), 6);

        send(6'h10, G); send(fp(6'h00), G); send(6'h20, G);
        send(6'h10, G); send(fp(6'h01), G);
        send(6'h30, G); send(6'h20, G);
        chk("abort cpol", int'(u_if.cpol), 0);

        send(6'h12, G); send(fp(6'h01), G);
        chk("bad addr err", int'(u_if.cfg_err), 1);

`ifdef SPI_CFG_PARITY_EN
        send(6'h11, G); send(6'h05, G);
        chk("parity err", int'(u_if.cfg_err), 1);
        send(6'h11, G); send(6'h25, G); send(6'h20, G);
        chk("parity ok width", int'(u_if.spi_width), 5);
`endif

        send(6'h11, G);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid-frame reset width", int'(u_if.spi_width), DW);
        send(6'h20, G);
        chk("post-reset commit cpol", int'(u_if.cpol), 0);
        chk("post-reset commit err",  int'(u_if.cfg_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
